running_light_ctrl: RTL and testbench
=====================================

Name: running_light_ctrl

Overview:
- Parametrised successor to the 4-LED running light: N_LED outputs, runtime step period and four pattern modes.
- A single sys_clk domain with an internal tick enable, so no derived clock is used as a flop clock.
- Sits between board pushbuttons/switches and LED pins. An optional PWM stage provides dimming.

Parameters:
- N_LED, 4, number of LED outputs; legal range 2..32.
- CNT_W, 26, width of the prescaler counter and of the period_cyc input.
- LED_ACTIVE_LOW, 1, when 1 the led outputs are inverted (lit = 0), matching the board.
- PWM_W, 4, width of the duty input; used only with LED_PWM_EN.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst  in  1  asynchronous, active-high reset.
- enable  in  1  1 = prescaler and pattern advance; 0 = freeze pattern, hold prescaler count.
- mode  in  2  00 shift-left, 01 shift-right, 10 bounce, 11 bar-fill.
- period_cyc  in  CNT_W  sys_clk cycles per step; 0 is treated as 1.
- duty  in  PWM_W  brightness; used only with LED_PWM_EN.
- led  out  N_LED  LED drive, polarity per LED_ACTIVE_LOW.
- pos  out  $clog2(N_LED)  index of the current head LED.
- step_tick  out  1  one-cycle pulse, registered in the same cycle the pattern advances.

Behaviour:
- Reset (async assert, sys_rst=1):
  - prescaler = 0, pos = 0, dir = up, step_tick = 0.
  - Logical pattern = one-hot bit0, so led = ~1 when LED_ACTIVE_LOW=1 and 1 otherwise.
  - Release is synchronous to sys_clk; the first step occurs period_cyc cycles after release.
- Prescaler:
  - Counts 0..P-1, where P = max(period_cyc, 1).
  - period_cyc is sampled only at wrap, so a mid-count change applies to the next step.
  - On wrap with enable=1, step_tick=1 for exactly one cycle and the pattern advances in the same clock edge.
- enable=0: prescaler holds, no tick, pattern and led hold.
- State machine:
  - States: IDLE (after reset, exits on the first enable=1), RUN, PAUSE (enable=0).
  - The only visible effect of the states is hold vs advance.
- Mode is sampled at each step. A mode change never glitches led between steps.
- Per step (logical pattern, bit i = LED i):
  - Shift-left: pos = (pos+1) mod N_LED; pattern = one-hot pos; N_LED-1 wraps to 0.
  - Shift-right: pos = (pos-1) mod N_LED; 0 wraps to N_LED-1.
  - Bounce:
    - pos moves in dir; at N_LED-1 dir flips to down, at 0 it flips to up.
    - Endpoints are shown once per sweep, giving a period of 2*N_LED-2 steps.
  - Bar-fill: pattern = bits 0..pos set; pos increments; after all-ones the pattern returns to bit0 only (pos=0). Period is N_LED steps.
- Mode switch mid-run:
  - pos is retained and pattern is recomputed for the new mode at the next step.
  - Entering bounce keeps dir. If pos is at an endpoint, dir is forced away from it.
- led is a registered output: led = pattern XOR {N_LED{LED_ACTIVE_LOW}}. It changes only on step edges or reset.
- Reset mid-run: immediate return to reset values regardless of mode or prescaler state.

Optional Feature:
- Macro: RUNNING_LIGHT_PWM_EN.
- Defined:
  - A free-running PWM_W-bit counter gates lit LEDs; an LED is lit while pwm_cnt < duty.
  - duty = 0 gives all LEDs dark; duty = all-ones gives lit for 2^PWM_W - 1 of 2^PWM_W cycles.
  - Gating is applied before polarity inversion, and the led output register is kept.
- Undefined: the duty port is present but ignored, and led = pattern with polarity applied.

Decomposition:
- Shared package running_light_pkg:
  - Mode encodings MODE_SHL, MODE_SHR, MODE_BOUNCE, MODE_BAR.
  - State encodings ST_IDLE, ST_RUN, ST_PAUSE.
  - Default CNT_W and the 50 MHz default period constant (50_000_000 cycles, 1 Hz).
- Sub-module tick_gen (prescaler plus step_tick, parameter CNT_W), reusable by other lab blocks.

Test Plan:
- Configuration for all scenarios: N_LED=4, LED_ACTIVE_LOW=1, period_cyc=3, enable=1.
- Shift-left: hold reset, then release -> led=4'b1110 at reset; step_tick every 3 cycles; led sequence 1101, 1011, 0111, 1110.
- Shift-right from reset -> led 0111, 1011, 1101, 1110; pos 3, 2, 1, 0.
- Bounce -> pos 1, 2, 3, 2, 1, 0, 1, which is a 6-step period.
- Bar-fill -> logical pattern 0011, 0111, 1111, 0001 (led 1100, 1000, 0000, 1110).
- enable=0 for 10 cycles mid-count -> no step_tick and led constant; after re-enable, the next tick arrives after the remaining count.
- Pause and reset edge cases:
  - Change period_cyc from 3 to 5 mid-count -> the current step still completes in 3 cycles and the next takes 5.
  - Assert sys_rst mid-step in bounce -> led=1110 and pos=0 immediately, without waiting for a clock edge.
- With RUNNING_LIGHT_PWM_EN defined and duty=4 (PWM_W=4) -> the lit LED is low for 4 of every 16 cycles.

Source files
------------

// File: rtl/running_light_pkg.sv
// Shared encodings and defaults for the running-light lab blocks.
package running_light_pkg;

  typedef enum logic [1:0] {
    MODE_SHL    = 2'b00,
    MODE_SHR    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_BAR    = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_e;

  localparam int CNT_W_DEF  = 26;
  localparam int PERIOD_1HZ = 50_000_000;

endpackage

// File: rtl/running_light_ctrl_tick_gen.sv
// Step prescaler: counts 0..P-1 with P = max(period, 1) and emits a step strobe
// plus a registered one-cycle tick aligned with the edge that consumes the strobe.
module tick_gen
  import running_light_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] period_i,
  output logic             adv_o,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] per_s;
  logic             tick_q;

  // The period is taken from the input at the first count of each step, so a
  // change mid-count only affects the following step.
  always_comb begin
    if (cnt_q == {CNT_W{1'b0}}) begin
      if (period_i == {CNT_W{1'b0}}) begin
        per_s = CNT_W'(1);
      end else begin
        per_s = period_i;
      end
    end else begin
      per_s = per_q;
    end

    adv_o = en_i && (cnt_q == (per_s - CNT_W'(1)));

    if (!en_i) begin
      cnt_d = cnt_q;
      per_d = per_q;
    end else if (adv_o) begin
      cnt_d = {CNT_W{1'b0}};
      per_d = per_s;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      per_d = per_s;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= {CNT_W{1'b0}};
      per_q  <= {CNT_W{1'b0}};
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      tick_q <= adv_o;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/running_light_ctrl.sv
// N-LED running light with four pattern modes and a runtime step period.
// Optional PWM dimming is built when RUNNING_LIGHT_PWM_EN is defined.
module running_light_ctrl
  import running_light_pkg::*;
#(
  parameter int N_LED          = 4,
  parameter int CNT_W          = CNT_W_DEF,
  parameter bit LED_ACTIVE_LOW = 1'b1,
  parameter int PWM_W          = 4
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     enable,
  input  logic [1:0]               mode,
  input  logic [CNT_W-1:0]         period_cyc,
  input  logic [PWM_W-1:0]         duty,
  output logic [N_LED-1:0]         led,
  output logic [$clog2(N_LED)-1:0] pos,
  output logic                     step_tick
);

  localparam int              PW      = $clog2(N_LED);
  localparam logic [N_LED-1:0] POL     = {N_LED{LED_ACTIVE_LOW}};
  localparam logic [N_LED-1:0] PAT_RST = {{(N_LED-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]    POS_TOP = PW'(N_LED - 1);

  state_e           st_q, st_d;
  logic             count_en_s;
  logic             adv_s;
  mode_e            mode_s;
  logic [PW-1:0]    pos_q, pos_d;
  logic             dir_q, dir_d;
  logic [N_LED-1:0] pat_q, pat_d;
  logic [N_LED-1:0] led_q, led_d;

  assign mode_s = mode_e'(mode);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      st_q <= ST_IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d       = st_q;
    count_en_s = 1'b0;
    case (st_q)
      ST_IDLE:  if (enable) st_d = ST_RUN; else st_d = ST_IDLE;
      ST_RUN:   if (enable) st_d = ST_RUN; else st_d = ST_PAUSE;
      ST_PAUSE: if (enable) st_d = ST_RUN; else st_d = ST_PAUSE;
      default:  st_d = ST_IDLE;
    endcase
    count_en_s = (st_d == ST_RUN);
  end

  tick_gen #(
    .CNT_W (CNT_W)
  ) u_tick_gen (
    .clk_i    (sys_clk),
    .rst_i    (sys_rst),
    .en_i     (count_en_s),
    .period_i (period_cyc),
    .adv_o    (adv_s),
    .tick_o   (step_tick)
  );

  // Bounce forces dir away from an endpoint before moving, which also covers
  // entering bounce mode while parked on an end LED.
  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    pat_d = pat_q;
    if (adv_s) begin
      case (mode_s)
        MODE_SHL, MODE_BAR: begin
          if (pos_q == POS_TOP) pos_d = {PW{1'b0}}; else pos_d = pos_q + PW'(1);
        end
        MODE_SHR: begin
          if (pos_q == {PW{1'b0}}) pos_d = POS_TOP; else pos_d = pos_q - PW'(1);
        end
        MODE_BOUNCE: begin
          if (pos_q == POS_TOP) dir_d = 1'b0;
          else if (pos_q == {PW{1'b0}}) dir_d = 1'b1;
          else dir_d = dir_q;
          if (dir_d) pos_d = pos_q + PW'(1); else pos_d = pos_q - PW'(1);
        end
        default: pos_d = pos_q;
      endcase
      for (int i = 0; i < N_LED; i++) begin
        if (mode_s == MODE_BAR) pat_d[i] = (PW'(i) <= pos_d);
        else pat_d[i] = (PW'(i) == pos_d);
      end
    end else begin
      pos_d = pos_q;
      dir_d = dir_q;
      pat_d = pat_q;
    end
  end

`ifdef RUNNING_LIGHT_PWM_EN
  logic [PWM_W-1:0] pwm_q;
  logic             lit_s;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pwm_q <= {PWM_W{1'b0}};
    end else begin
      pwm_q <= pwm_q + PWM_W'(1);
    end
  end

  assign lit_s = (pwm_q < duty);
  assign led_d = (pat_d & {N_LED{lit_s}}) ^ POL;
`else
  logic unused_duty_s;
  assign unused_duty_s = ^duty;
  assign led_d = pat_d ^ POL;
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pos_q <= {PW{1'b0}};
      dir_q <= 1'b1;
      pat_q <= PAT_RST;
      led_q <= PAT_RST ^ POL;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
      pat_q <= pat_d;
      led_q <= led_d;
    end
  end

  assign led = led_q;
  assign pos = pos_q;

endmodule

// File: tb/tb_running_light_ctrl.sv
// Self-checking bench for running_light_ctrl (N_LED=4, active-low LEDs).
module tb_running_light_ctrl;
  import running_light_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic [25:0] period_cyc = 26'd3;
  logic [3:0]  duty = 4'd4;
  logic [3:0]  led;
  logic [1:0]  pos;
  logic        step_tick;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  int         m_pos, m_dir, m_elapsed, m_len;
  logic [3:0] m_pat;
  logic       m_tick;

  running_light_ctrl #(
    .N_LED(4), .CNT_W(26), .LED_ACTIVE_LOW(1'b1), .PWM_W(4)
  ) dut (
    .sys_clk(clk), .sys_rst(rst), .enable(enable), .mode(mode),
    .period_cyc(period_cyc), .duty(duty), .led(led), .pos(pos), .step_tick(step_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_pos = 0; m_dir = 1; m_elapsed = 0; m_len = 0; m_pat = 4'b0001; m_tick = 1'b0;
  endtask

  task automatic model_step();
    case (mode)
      2'b00: begin m_pos = (m_pos + 1) % 4; m_pat = 4'b0001 << m_pos; end
      2'b01: begin m_pos = (m_pos + 3) % 4; m_pat = 4'b0001 << m_pos; end
      2'b10: begin
        if (m_pos == 3) m_dir = -1;
        else if (m_pos == 0) m_dir = 1;
        m_pos = m_pos + m_dir;
        m_pat = 4'b0001 << m_pos;
      end
      default: begin
        m_pos = (m_pos + 1) % 4;
        m_pat = 4'((5'd1 << (m_pos + 1)) - 5'd1);
      end
    endcase
  endtask

  // Step length is fixed by the period seen on the first enabled cycle of a step.
  task automatic model_edge();
    m_tick = 1'b0;
    if (rst) model_reset();
    else if (enable) begin
      if (m_len == 0) m_len = (period_cyc == 26'd0) ? 1 : int'(period_cyc);
      m_elapsed++;
      if (m_elapsed >= m_len) begin
        m_elapsed = 0; m_len = 0; m_tick = 1'b1;
        model_step();
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (led !== 4'b1110) begin n_err++; $display("FAIL reset_led: got %b want 1110", led); end
    n_chk++;
    if (pos !== 2'd0) begin n_err++; $display("FAIL reset_pos: got %0d want 0", pos); end
    n_chk++;
    if (step_tick !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %b want 0", step_tick); end
    rst = 1'b0;
  endtask

  task automatic test_shift_left();
    logic [3:0] exp_led [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    mode = MODE_SHL; enable = 1'b1; period_cyc = 26'd3;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      for (int c = 1; c <= 3; c++) begin
        @(posedge clk); @(negedge clk);
        n_chk++;
        if (step_tick !== (c == 3)) begin
          n_err++; $display("FAIL shl_tick step%0d cyc%0d: got %b want %b", k, c, step_tick, (c == 3));
        end
      end
      n_chk++;
      if (led !== exp_led[k]) begin n_err++; $display("FAIL shl_led step%0d: got %b want %b", k, led, exp_led[k]); end
    end
  endtask

  task automatic test_shift_right();
    logic [3:0] exp_led [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    logic [1:0] exp_pos [4] = '{2'd3, 2'd2, 2'd1, 2'd0};
    mode = MODE_SHR;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_chk++;
      if (led !== exp_led[k] || pos !== exp_pos[k]) begin
        n_err++; $display("FAIL shr step%0d: got led=%b pos=%0d want led=%b pos=%0d", k, led, pos, exp_led[k], exp_pos[k]);
      end
    end
  endtask

  task automatic test_bounce();
    logic [1:0] exp_pos [7] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1};
    mode = MODE_BOUNCE;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_chk++;
      if (pos !== exp_pos[k] || led !== ~(4'b0001 << exp_pos[k])) begin
        n_err++; $display("FAIL bounce step%0d: got pos=%0d led=%b want pos=%0d", k, pos, led, exp_pos[k]);
      end
    end
  endtask

  task automatic test_bar_fill();
    logic [3:0] exp_led [4] = '{4'b1100, 4'b1000, 4'b0000, 4'b1110};
    mode = MODE_BAR;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_chk++;
      if (led !== exp_led[k]) begin n_err++; $display("FAIL bar step%0d: got %b want %b", k, led, exp_led[k]); end
    end
  endtask

  task automatic test_enable_pause();
    mode = MODE_SHL;
    do_reset();
    @(posedge clk); @(negedge clk);
    enable = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); @(negedge clk);
      n_chk++;
      if (step_tick !== 1'b0 || led !== 4'b1110) begin
        n_err++; $display("FAIL pause cyc%0d: got tick=%b led=%b want tick=0 led=1110", c, step_tick, led);
      end
    end
    enable = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      @(posedge clk); @(negedge clk);
      n_chk++;
      if (step_tick !== (c == 2)) begin
        n_err++; $display("FAIL resume_tick cyc%0d: got %b want %b", c, step_tick, (c == 2));
      end
    end
    n_chk++;
    if (led !== 4'b1101) begin n_err++; $display("FAIL resume_led: got %b want 1101", led); end
  endtask

  task automatic test_period_change();
    mode = MODE_SHL; period_cyc = 26'd3;
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); @(negedge clk);
      if (c == 1) period_cyc = 26'd5;
      n_chk++;
      if (step_tick !== (c == 3 || c == 8)) begin
        n_err++; $display("FAIL period_change cyc%0d: got tick=%b want %b", c, step_tick, (c == 3 || c == 8));
      end
    end
    period_cyc = 26'd3;
  endtask

  task automatic test_reset_mid_bounce();
    mode = MODE_BOUNCE;
    do_reset();
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (pos !== 2'd3) begin n_err++; $display("FAIL pre_reset_pos: got %0d want 3", pos); end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (led !== 4'b1110 || pos !== 2'd0 || step_tick !== 1'b0) begin
      n_err++; $display("FAIL async_reset: got led=%b pos=%0d tick=%b want 1110/0/0", led, pos, step_tick);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (pos !== 2'd1 || step_tick !== 1'b1) begin
      n_err++; $display("FAIL post_reset_step: got pos=%0d tick=%b want 1/1", pos, step_tick);
    end
  endtask

  task automatic test_random();
    mode = MODE_SHL; enable = 1'b1; period_cyc = 26'd3;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 99) == 0) begin rst = 1'b1; model_reset(); end
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 14) == 0) period_cyc = 26'($urandom_range(0, 4));
      @(posedge clk);
      model_edge();
      @(negedge clk);
      n_chk++;
      if (led !== (m_pat ^ 4'b1111) || pos !== m_pos[1:0] || step_tick !== m_tick) begin
        n_err++;
        $display("FAIL random cyc%0d: got led=%b pos=%0d tick=%b want led=%b pos=%0d tick=%b",
                 c, led, pos, step_tick, m_pat ^ 4'b1111, m_pos[1:0], m_tick);
      end
    end
    rst = 1'b0;
  endtask

`ifdef RUNNING_LIGHT_PWM_EN
  task automatic test_pwm();
    int lit_cnt;
    int other_bad;
    lit_cnt = 0; other_bad = 0;
    enable = 1'b0; duty = 4'd4;
    do_reset();
    repeat (3) @(negedge clk);
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (led[0] === 1'b0) lit_cnt++;
      if (led[3:1] !== 3'b111) other_bad++;
    end
    n_chk++;
    if (lit_cnt != 8) begin n_err++; $display("FAIL pwm_duty: lit %0d of 32 cycles want 8", lit_cnt); end
    n_chk++;
    if (other_bad != 0) begin n_err++; $display("FAIL pwm_dark: %0d cycles with unlit LEDs driven want 0", other_bad); end
    enable = 1'b1;
  endtask
`endif

  initial begin
    $display("default 1 Hz period = %0d cycles, counter width %0d", PERIOD_1HZ, CNT_W_DEF);
    test_reset();
`ifdef RUNNING_LIGHT_PWM_EN
    test_pwm();
`else
    test_shift_left();
    test_shift_right();
    test_bounce();
    test_bar_fill();
    test_enable_pause();
    test_period_change();
    test_reset_mid_bounce();
    test_random();
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
